noc_flit_sender: RTL and testbench

NOC_FLIT_SENDER -- requirements
Module: noc_flit_sender

---
 rtl/params_noc.sv | 34 +++
 rtl/tx_flit_queue.sv | 63 ++++++
 rtl/noc_flit_sender.sv | 114 +++++++++++
 tb/tb_noc_flit_sender.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_noc.sv
// ============================================================================
// params_noc : shared flit format, flit labels and packet-tracking state.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package params_noc;

  localparam int x_Des              = 4;
  localparam int y_Des              = 4;
  localparam int header_Payloadsize = 8;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t                   flit_label;
    logic [x_Des-1:0]              x_Dest;
    logic [y_Des-1:0]              y_Dest;
    logic [header_Payloadsize-1:0] payload;
  } flit_Data_noVC;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

endpackage

`default_nettype wire

// File: rtl/tx_flit_queue.sv
// ============================================================================
// tx_flit_queue : circular flit FIFO; occupancy counter separates full/empty.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tx_flit_queue
  import params_noc::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  flit_Data_noVC i_push_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output flit_Data_noVC o_head
);

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

  flit_Data_noVC  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  // A push into a full queue is dropped even when a pop frees a slot this edge.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_flit_sender.sv
// ============================================================================
// noc_flit_sender : queues local flits and sends them under on/off credit.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module noc_flit_sender
  import params_noc::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  flit_Data_noVC    in_Data,
  input  logic             in_valid,
  output logic             in_ready,
  output flit_Data_noVC    out_Data,
  output logic             out_valid,
  input  logic             on_off_i,
  output logic [CNT_W-1:0] sent_count,
  output logic             protocol_err
);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  flit_Data_noVC    w_head;

  logic             r_on_q;
  flit_Data_noVC    r_out_data;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_sent_count;
  logic             r_protocol_err;
  pkt_state_t       r_state;

  assign in_ready     = !w_full;
  assign w_push       = in_valid && !w_full;
  // Send decision uses only the registered credit, never the raw input.
  assign w_pop        = !w_empty && r_on_q;

  assign out_Data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign sent_count   = r_sent_count;
  assign protocol_err = r_protocol_err;

  tx_flit_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (in_Data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_on_q       <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_sent_count <= '0;
    end else begin
      r_on_q      <= on_off_i;
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_data   <= w_head;
        r_sent_count <= r_sent_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_protocol_err <= 1'b0;
    end else if (w_push) begin
      case (r_state)
        IDLE: begin
          case (in_Data.flit_label)
            HEAD:     r_state <= IN_PKT;
            HEADTAIL: r_state <= IDLE;
            default: begin
              r_state        <= IDLE;
              r_protocol_err <= 1'b1;
            end
          endcase
        end
        IN_PKT: begin
          case (in_Data.flit_label)
            BODY:     r_state <= IN_PKT;
            TAIL:     r_state <= IDLE;
            HEAD: begin
              r_state        <= IN_PKT;
              r_protocol_err <= 1'b1;
            end
            default: begin
              r_state        <= IDLE;
              r_protocol_err <= 1'b1;
            end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_flit_sender.sv
// ============================================================================
// tb_noc_flit_sender : directed stimulus with a scoreboard queue of flits.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_noc_flit_sender;
  import params_noc::*;

  localparam int QD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  flit_Data_noVC in_Data;
  logic          in_valid;
  logic          in_ready;
  flit_Data_noVC out_Data;
  logic          out_valid;
  logic          on_off_i;
  logic [CW-1:0] sent_count;
  logic          protocol_err;

  int            total  = 0;
  int            bad    = 0;
  int            m_sent = 0;
  int            n_out  = 0;
  flit_Data_noVC exp_q[$];

  always #5 clk = ~clk;

  noc_flit_sender #(
    .QUEUE_DEPTH (QD),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_Data      (in_Data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_Data     (out_Data),
    .out_valid    (out_valid),
    .on_off_i     (on_off_i),
    .sent_count   (sent_count),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic flit_Data_noVC mk(input flit_label_t l, input logic [3:0] x,
                                       input logic [3:0] y, input logic [7:0] p);
    flit_Data_noVC f;
    f.flit_label = l;
    f.x_Dest     = x;
    f.y_Dest     = y;
    f.payload    = p;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Offers one flit for one edge; the expected copy is queued only if accepted.
  task automatic drive(input flit_Data_noVC f, output logic acc);
    in_valid = 1'b1;
    in_Data  = f;
    @(negedge clk);
    acc = in_ready;
    if (acc) exp_q.push_back(f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_out++;
        m_sent++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_flit: got=%0h want=none", out_Data);
        end else begin
          flit_Data_noVC e;
          e = exp_q.pop_front();
          chk("out_data", {14'h0, out_Data}, {14'h0, e});
        end
        chk("sent_count", 32'(sent_count), 32'(m_sent));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin : stim
    logic acc;
    int   base;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    on_off_i = 1'b0;
    in_Data  = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt", sent_count, 0);
    chk("rst_perr", protocol_err, 0);
    tick();
    rst_n    = 1'b1;
    on_off_i = 1'b1;
    tick();

    // Single flit latency
    drive(mk(HEAD, 4'd3, 4'd1, 8'h11), acc);
    chk("acc_head", acc, 1);
    @(negedge clk);
    chk("lat_edge1", out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_edge2", out_valid, 1);
    chk("cnt_first", sent_count, 1);
    tick();

    // Fill with credit off, then release
    on_off_i = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(mk(i == 3 ? TAIL : BODY, 4'd1, 4'd2, 8'(8'h20 + i)), acc);
      chk("acc_fill", acc, 1);
    end
    @(negedge clk);
    chk("full_ready", in_ready, 0);
    chk("stall_valid", out_valid, 0);
    tick();
    drive(mk(HEAD, 4'd9, 4'd9, 8'hEE), acc);
    chk("full_reject", acc, 0);
    on_off_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("burst_valid", out_valid, 1);
    end
    chk("burst_cnt", sent_count, 5);
    tick();
    @(negedge clk);
    chk("burst_end", out_valid, 0);
    tick();

    // Continuous stream, one flit per cycle
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      drive(mk(i == 0 ? HEAD : (i == 19 ? TAIL : BODY), 4'(i), 4'd5, 8'(8'h40 + i)), acc);
      chk("stream_acc", acc, 1);
    end
    tick();
    settle();
    chk("stream_cnt", n_out - base, 20);
    chk("stream_drained", exp_q.size(), 0);
    tick();

    // One-cycle credit drop mid-stream
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      flit_Data_noVC f;
      f = mk(i == 0 ? HEADTAIL : (i == 1 ? HEAD : (i == 7 ? TAIL : BODY)),
             4'd7, 4'(i), 8'(8'h80 + i));
      if (i == 3) on_off_i = 1'b0;
      if (i == 4) on_off_i = 1'b1;
      if (i == 4 || i == 5) begin
        fork
          drive(f, acc);
          begin
            @(negedge clk);
            if (i == 4) chk("drop_last", out_valid, 1);
            else        chk("drop_gap", out_valid, 0);
          end
        join
      end else begin
        drive(f, acc);
      end
      chk("drop_acc", acc, 1);
    end
    tick();
    settle();
    chk("drop_cnt_a", n_out - base, 7);
    tick();
    settle();
    chk("drop_cnt_b", n_out - base, 8);
    chk("perr_legal", protocol_err, 0);
    tick();

    // Illegal label sequence
    base = n_out;
    drive(mk(BODY, 4'd2, 4'd2, 8'hA0), acc);
    @(negedge clk);
    chk("perr_rise", protocol_err, 1);
    tick();
    drive(mk(HEAD, 4'd2, 4'd2, 8'hA1), acc);
    drive(mk(HEAD, 4'd2, 4'd2, 8'hA2), acc);
    drive(mk(TAIL, 4'd2, 4'd2, 8'hA3), acc);
    tick();
    tick();
    settle();
    chk("perr_cnt", n_out - base, 4);
    chk("perr_sticky", protocol_err, 1);
    tick();

    // Reset with flits queued mid-packet
    on_off_i = 1'b0;
    tick();
    tick();
    drive(mk(HEAD, 4'd6, 4'd6, 8'hC0), acc);
    drive(mk(BODY, 4'd6, 4'd6, 8'hC1), acc);
    drive(mk(BODY, 4'd6, 4'd6, 8'hC2), acc);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    m_sent = 0;
    @(negedge clk);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_ready", in_ready, 1);
    chk("rst2_cnt", sent_count, 0);
    chk("rst2_perr", protocol_err, 0);
    tick();
    rst_n    = 1'b1;
    on_off_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst2_cnt_hold", sent_count, 0);
    drive(mk(HEADTAIL, 4'd1, 4'd1, 8'hD5), acc);
    chk("post_rst_acc", acc, 1);
    tick();
    tick();
    settle();
    chk("post_rst_perr", protocol_err, 0);
    chk("post_rst_cnt", sent_count, 1);
    chk("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
